// File: rtl/ram_ext_loader.sv
// Byte-stream loader: packs 8 bytes (first byte in the MSBs) per 64-bit word and
// writes consecutive words into the RAM external port starting at a programmed base.
module ram_ext_loader #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        word_cnt,
  input  logic              s_valid,
  input  logic [BYTE_W-1:0] s_data,
  output logic              s_ready,
  output logic              ram_mode,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_ext_addr,
  output logic [DATA_W-1:0] ram_ext_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BYTES  = DATA_W / BYTE_W;
  localparam int unsigned BIDX_W = $clog2(BYTES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   base_q;
  logic [7:0]          cnt_q;
  logic [7:0]          word_idx;
  logic [BIDX_W-1:0]   byte_idx;
  logic [DATA_W-1:0]   pack;
  logic [DATA_W-1:0]   pack_nxt;
  logic                accept;
  logic                last_byte;

  assign accept    = (state == COLLECT) && s_valid;
  assign last_byte = accept && (byte_idx == BIDX_W'(BYTES - 1));

  // Pack register with the incoming byte dropped into its slot
  always_comb begin
    pack_nxt = pack;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (byte_idx == BIDX_W'(i)) begin
        pack_nxt[DATA_W-1-BYTE_W*i -: BYTE_W] = s_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (word_cnt == 8'd0) ? DONE : COLLECT;
      COLLECT: if (last_byte) state_nxt = WRITE;
      WRITE:   state_nxt = (8'(word_idx + 8'd1) == cnt_q) ? DONE : COLLECT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready  = 1'b0;
    ram_mode = 1'b0;
    ram_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      COLLECT: begin
        s_ready  = 1'b1;
        ram_mode = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        ram_mode = 1'b1;
        ram_we   = 1'b1;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Address/data are loaded on the 8th byte so they are valid during WRITE and hold afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q       <= '0;
      cnt_q        <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      pack         <= '0;
      ram_ext_addr <= '0;
      ram_ext_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            cnt_q    <= word_cnt;
            word_idx <= '0;
            byte_idx <= '0;
            pack     <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            pack     <= pack_nxt;
            byte_idx <= BIDX_W'(byte_idx + 1'b1);
          end
          if (last_byte) begin
            ram_ext_addr <= ADDR_W'(base_q + word_idx[ADDR_W-1:0]);
            ram_ext_data <= pack_nxt;
          end
        end
        WRITE: begin
          word_idx <= 8'(word_idx + 8'd1);
          byte_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ext_loader.sv
// Randomized and directed bench for ram_ext_loader against a word/byte-queue reference model.
module tb_ram_ext_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  base_addr;
  logic [7:0]  word_cnt;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        ram_mode;
  logic        ram_we;
  logic [6:0]  ram_ext_addr;
  logic [63:0] ram_ext_data;
  logic        busy;
  logic        done;

  ram_ext_loader #(.ADDR_W(7), .DATA_W(64), .BYTE_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .ram_mode(ram_mode),
    .ram_we(ram_we), .ram_ext_addr(ram_ext_addr), .ram_ext_data(ram_ext_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int     ncheck = 0;
  int     nerr   = 0;
  longint cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncheck++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a load is a list of words built from the accepted byte stream
  bit          m_active = 0;
  bit          m_we     = 0;
  bit          m_done   = 0;
  bit          nwe;
  bit          ndone;
  logic [6:0]  m_base;
  logic [7:0]  m_cnt;
  int          m_words;
  logic [6:0]  m_addr;
  logic [63:0] m_data;
  logic [7:0]  m_bytes[$];
  logic [6:0]  last_addr = '0;
  logic [63:0] last_data = '0;

  logic [6:0]  log_addr[$];
  logic [63:0] log_data[$];
  int          done_cnt  = 0;
  longint      start_cyc = 0;
  longint      done_cyc  = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("ram_we", ram_we, m_we);
      check("done", done, m_done);
      check("s_ready", s_ready, m_active && !m_we);
      check("busy", busy, m_active);
      check("ram_mode", ram_mode, m_active);
      if (m_we) begin
        last_addr = m_addr;
        last_data = m_data;
      end
      check("ram_ext_addr", ram_ext_addr, last_addr);
      check("ram_ext_data", ram_ext_data, last_data);
      if (ram_we) begin
        log_addr.push_back(ram_ext_addr);
        log_data.push_back(ram_ext_data);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end

      nwe   = 0;
      ndone = 0;
      if (rst) begin
        m_active = 0;
        m_bytes.delete();
        last_addr = '0;
        last_data = '0;
      end else if (m_done) begin
        // back to idle next cycle
      end else if (!m_active) begin
        if (start) begin
          start_cyc = cyc;
          if (word_cnt == 8'd0) begin
            ndone = 1;
          end else begin
            m_active = 1;
            m_base   = base_addr;
            m_cnt    = word_cnt;
            m_words  = 0;
            m_bytes.delete();
          end
        end
      end else if (m_we) begin
        m_words++;
        if (m_words == int'(m_cnt)) begin
          m_active = 0;
          ndone    = 1;
        end
      end else if (s_valid) begin
        m_bytes.push_back(s_data);
        if (m_bytes.size() == 8) begin
          m_data = '0;
          for (int i = 0; i < 8; i++) m_data = {m_data[55:0], m_bytes[i]};
          m_addr = 7'((int'(m_base) + m_words) % 128);
          nwe    = 1;
          m_bytes.delete();
        end
      end
      m_we   = nwe;
      m_done = ndone;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [6:0] b, input logic [7:0] n);
    base_addr = b;
    word_cnt  = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit stall);
    bit acc;
    int guard;
    guard  = 0;
    s_data = b;
    forever begin
      s_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      acc     = s_valid && s_ready;
      tick();
      if (acc) break;
      guard++;
      if (guard > 50) begin
        check("byte accept timeout", 64'(s_ready), 64'd1);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    i = 0;
    while (done !== 1'b1 && i < budget) begin
      tick();
      i++;
    end
    check(name, 64'(done), 64'd1);
    tick();
  endtask

  int n0;
  int d0;

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; base_addr = '0; word_cnt = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset ctrl", {s_ready, ram_mode, ram_we, busy, done, ram_ext_addr}, 64'd0);
    check("reset data", ram_ext_data, 64'd0);

    // single word
    n0 = log_addr.size();
    do_start(7'd5, 8'd1);
    for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b0);
    check("t1 we after 8th", 64'(ram_we), 64'd1);
    check("t1 ready in write", 64'(s_ready), 64'd0);
    wait_done("t1 done", 5);
    check("t1 count", 64'(log_addr.size() - n0), 64'd1);
    check("t1 addr", 64'(log_addr[n0]), 64'd5);
    check("t1 data", log_data[n0], 64'h0102030405060708);
    check("t1 latency", 64'(done_cyc - start_cyc), 64'd10);

    // wrap-around
    n0 = log_addr.size();
    do_start(7'd127, 8'd2);
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i), 1'b0);
      if (i == 7 || i == 15) check("t2 ready in write", 64'(s_ready), 64'd0);
    end
    wait_done("t2 done", 5);
    check("t2 addr0", 64'(log_addr[n0]), 64'd127);
    check("t2 data0", log_data[n0], 64'h0001020304050607);
    check("t2 addr1", 64'(log_addr[n0+1]), 64'd0);
    check("t2 data1", log_data[n0+1], 64'h08090a0b0c0d0e0f);
    check("t2 latency", 64'(done_cyc - start_cyc), 64'd19);

    // stalls
    n0 = log_addr.size();
    do_start(7'd20, 8'd1);
    for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b1);
    wait_done("t3 done", 10);
    check("t3 addr", 64'(log_addr[n0]), 64'd20);
    check("t3 data", log_data[n0], 64'h0102030405060708);

    // zero count
    n0 = log_addr.size();
    do_start(7'd33, 8'd0);
    check("t4 done", 64'(done), 64'd1);
    check("t4 mode", 64'(ram_mode), 64'd0);
    tick();
    check("t4 latency", 64'(done_cyc - start_cyc), 64'd1);
    check("t4 no write", 64'(log_addr.size() - n0), 64'd0);

    // reset mid-word
    do_start(7'd60, 8'd1);
    for (int i = 0; i < 5; i++) push_byte(8'hf0 + 8'(i), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5 ctrl zero", {s_ready, ram_mode, ram_we, busy, done, ram_ext_addr}, 64'd0);
    check("t5 data zero", ram_ext_data, 64'd0);
    n0 = log_addr.size();
    do_start(7'd9, 8'd1);
    for (int i = 0; i < 8; i++) push_byte(8'ha0 + 8'(i), 1'b0);
    wait_done("t5 done", 5);
    check("t5 count", 64'(log_addr.size() - n0), 64'd1);
    check("t5 addr", 64'(log_addr[n0]), 64'd9);
    check("t5 data", log_data[n0], 64'ha0a1a2a3a4a5a6a7);

    // start while busy
    n0 = log_addr.size();
    d0 = done_cnt;
    do_start(7'd3, 8'd2);
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        base_addr = 7'd50;
        start     = 1'b1;
      end
      push_byte(8'($urandom), 1'b0);
      start = 1'b0;
    end
    wait_done("t6 done", 5);
    repeat (12) tick();
    check("t6 count", 64'(log_addr.size() - n0), 64'd2);
    check("t6 addr0", 64'(log_addr[n0]), 64'd3);
    check("t6 addr1", 64'(log_addr[n0+1]), 64'd4);
    check("t6 done pulses", 64'(done_cnt - d0), 64'd1);

    // random loads
    for (int k = 0; k < 8; k++) begin
      automatic logic [7:0] n = 8'($urandom_range(0, 3));
      automatic bit stall = 1'($urandom_range(0, 1));
      do_start(7'($urandom_range(0, 127)), n);
      for (int i = 0; i < 8 * int'(n); i++) push_byte(8'($urandom), stall);
      wait_done("rand done", 20);
    end

    // long load wrapping past 128 words
    n0 = log_addr.size();
    do_start(7'd120, 8'd130);
    for (int i = 0; i < 8 * 130; i++) push_byte(8'($urandom), 1'b0);
    wait_done("long done", 5);
    check("long count", 64'(log_addr.size() - n0), 64'd130);
    check("long addr128", 64'(log_addr[n0+128]), 64'd120);
    check("long latency", 64'(done_cyc - start_cyc), 64'd1171);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", ncheck, nerr);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
